// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings, output-port codes and the
// switch-request one-hot bit positions used by router pipeline stages.
package noc_pkg;

  localparam logic [1:0] HDR    = 2'b10;
  localparam logic [1:0] BODY   = 2'b00;
  localparam logic [1:0] TAIL   = 2'b01;
  localparam logic [1:0] SINGLE = 2'b11;

  localparam logic [3:0] PORT_NONE = 4'd0;
  localparam logic [3:0] PORT_L    = 4'd1;
  localparam logic [3:0] PORT_E    = 4'd2;
  localparam logic [3:0] PORT_N    = 4'd3;
  localparam logic [3:0] PORT_W    = 4'd4;
  localparam logic [3:0] PORT_S    = 4'd5;

  // Bit order of the switch allocator request vector differs from port codes.
  localparam int OH_L = 0;
  localparam int OH_E = 1;
  localparam int OH_W = 2;
  localparam int OH_S = 3;
  localparam int OH_N = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } rc_state_t;

  function automatic logic [4:0] port_onehot(input logic [3:0] port);
    logic [4:0] oh;
    oh = 5'b00000;
    case (port)
      PORT_L:  oh[OH_L] = 1'b1;
      PORT_E:  oh[OH_E] = 1'b1;
      PORT_N:  oh[OH_N] = 1'b1;
      PORT_W:  oh[OH_W] = 1'b1;
      PORT_S:  oh[OH_S] = 1'b1;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Combinational dimension-ordered (X then Y) route decision for one router.
// Out-of-range destinations are steered to the local port and flagged.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int DEST_W  = 4,
  parameter int X_NODES = 4,
  parameter int Y_NODES = 4,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 1
) (
  input  logic [DEST_W-1:0] dest_x,
  input  logic [DEST_W-1:0] dest_y,
  output logic [3:0]        port,
  output logic              range_err
);

  logic signed [DEST_W:0] xdiff;
  logic signed [DEST_W:0] ydiff;

  // One extra bit keeps the subtraction sign-correct for any unsigned dest.
  assign xdiff = $signed({1'b0, dest_x}) - $signed((DEST_W+1)'(CUR_X));
  assign ydiff = $signed({1'b0, dest_y}) - $signed((DEST_W+1)'(CUR_Y));

  assign range_err = ({1'b0, dest_x} >= (DEST_W+1)'(X_NODES)) ||
                     ({1'b0, dest_y} >= (DEST_W+1)'(Y_NODES));

  always_comb begin
    port = PORT_L;
    if (range_err)      port = PORT_L;
    else if (xdiff > 0) port = PORT_E;
    else if (xdiff < 0) port = PORT_W;
    else if (ydiff > 0) port = PORT_S;
    else if (ydiff < 0) port = PORT_N;
    else                port = PORT_L;
  end

endmodule

// File: rtl/route_compute_wh.sv
// Registered XY route-compute stage for a wormhole router input port: routes
// each header, holds the route for the rest of the packet, one-deep pipeline.
module route_compute_wh
  import noc_pkg::*;
#(
  parameter int FLIT_W  = 16,
  parameter int DEST_W  = 4,
  parameter int X_NODES = 4,
  parameter int Y_NODES = 4,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        port_num,
  output logic [4:0]        req_onehot,
  output logic              busy,
  output logic              dest_err,
  output logic              proto_err
);

  // Handshake: a flit moves on a cycle where valid and ready are both high;
  // in_ready only depends on the output register, so the stage streams one
  // flit per cycle while the switch keeps draining it.

  rc_state_t   state, state_next;
  logic [1:0]  in_type;
  logic        accept, is_head, drop, fwd;
  logic [3:0]  route_port;
  logic        route_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_type  = in_flit[FLIT_W-1 -: 2];
  assign is_head  = (in_type == HDR) || (in_type == SINGLE);
  // Body/tail without an open packet has no route to follow, so it is dropped.
  assign drop     = accept && (state == ST_IDLE) && !is_head;
  assign fwd      = accept && !drop;

  xy_route_calc #(
    .DEST_W  (DEST_W),
    .X_NODES (X_NODES),
    .Y_NODES (Y_NODES),
    .CUR_X   (CUR_X),
    .CUR_Y   (CUR_Y)
  ) u_route (
    .dest_x    (in_flit[DEST_W-1:0]),
    .dest_y    (in_flit[2*DEST_W-1:DEST_W]),
    .port      (route_port),
    .range_err (route_err)
  );

  always_comb begin
    state_next = state;
    if (accept) begin
      case (in_type)
        HDR:     state_next = ST_PKT;
        SINGLE:  state_next = ST_IDLE;
        TAIL:    state_next = ST_IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_flit  <= '0;
      out_valid <= 1'b0;
      port_num  <= PORT_NONE;
      dest_err  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_next;
      dest_err  <= accept && is_head && route_err;
      proto_err <= drop || (accept && is_head && (state == ST_PKT));
      if (fwd) begin
        out_flit  <= in_flit;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && is_head) port_num <= route_port;
    end
  end

  // busy is the FSM state itself, so it also serves as the state observation point.
  assign busy       = (state == ST_PKT);
  assign req_onehot = out_valid ? port_onehot(port_num) : 5'b00000;

endmodule

// File: tb/tb_route_compute_wh.sv
// Directed bench for route_compute_wh: a driver pushes expected
// {req, port, flit} on acceptance, a monitor pops on each output transfer.
module tb_route_compute_wh;

  localparam int FLIT_W = 16;
  localparam int EW     = 5 + 4 + FLIT_W;

  logic              clk;
  logic              rst;
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        port_num;
  logic [4:0]        req_onehot;
  logic              busy;
  logic              dest_err;
  logic              proto_err;

  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  route_compute_wh #(
    .FLIT_W (16), .DEST_W (4), .X_NODES (4), .Y_NODES (4), .CUR_X (0), .CUR_Y (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .port_num   (port_num),
    .req_onehot (req_onehot),
    .busy       (busy),
    .dest_err   (dest_err),
    .proto_err  (proto_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: starts at posedge+1, returns at posedge+1 after the accepting edge
  task automatic send(input logic [FLIT_W-1:0] flit, input bit fwd,
                      input logic [3:0] exp_port, input logic [4:0] exp_req,
                      output int stalls);
    bit got;
    stalls   = 0;
    got      = 0;
    in_flit  = flit;
    in_valid = 1'b1;
    while (!got && stalls < 50) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        if (fwd) exp_q.push_back({exp_req, exp_port, flit});
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", 32'(stalls), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_flit), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_flit", 32'(out_flit), 32'(e[FLIT_W-1:0]));
        check("port_num", 32'(port_num), 32'(e[FLIT_W+3:FLIT_W]));
        check("req_onehot", 32'(req_onehot), 32'(e[EW-1:FLIT_W+4]));
      end
    end
  end

  initial begin
    int st;
    int tot;
    rst       = 1'b1;
    in_flit   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_port_num", 32'(port_num), 32'd0);
    check("rst_req", 32'(req_onehot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", {30'd0, dest_err, proto_err}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // header to East, body, tail
    send(16'h8011, 1, 4'd2, 5'b00010, st);
    @(negedge clk);
    check("hdr_out_valid", 32'(out_valid), 32'd1);
    check("hdr_port", 32'(port_num), 32'd2);
    check("hdr_req", 32'(req_onehot), 32'b00010);
    check("hdr_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    send(16'h0123, 1, 4'd2, 5'b00010, st);
    send(16'h4456, 1, 4'd2, 5'b00010, st);
    @(negedge clk);
    check("tail_busy_low", 32'(busy), 32'd0);
    check("tail_port_held", 32'(port_num), 32'd2);
    @(posedge clk);
    #1;

    // single-flit packets: North, then Local
    send(16'hC000, 1, 4'd3, 5'b10000, st);
    @(negedge clk);
    check("single_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    send(16'hC010, 1, 4'd1, 5'b00001, st);
    idle_cycle();

    // stalled header to South, then back-to-back bodies after release
    out_ready = 1'b0;
    send(16'h8030, 1, 4'd5, 5'b01000, st);
    in_flit  = 16'h0001;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_flit", 32'(out_flit), 32'h8030);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_port", 32'(port_num), 32'd5);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    tot = 0;
    send(16'h0001, 1, 4'd5, 5'b01000, st); tot += st;
    send(16'h0002, 1, 4'd5, 5'b01000, st); tot += st;
    send(16'h0003, 1, 4'd5, 5'b01000, st); tot += st;
    send(16'h4004, 1, 4'd5, 5'b01000, st); tot += st;
    check("b2b_stalls", 32'(tot), 32'd0);
    idle_cycle();

    // body with no open packet is dropped
    send(16'h0AAA, 0, 4'd0, 5'b0, st);
    @(negedge clk);
    check("drop_proto_err", 32'(proto_err), 32'd1);
    check("drop_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drop_proto_pulse", 32'(proto_err), 32'd0);
    @(posedge clk);
    #1;

    // header while busy reloads the route
    send(16'h8011, 1, 4'd2, 5'b00010, st);
    send(16'h0055, 1, 4'd2, 5'b00010, st);
    send(16'h8030, 1, 4'd5, 5'b01000, st);
    @(negedge clk);
    check("rehdr_proto_err", 32'(proto_err), 32'd1);
    check("rehdr_port", 32'(port_num), 32'd5);
    check("rehdr_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    send(16'h4066, 1, 4'd5, 5'b01000, st);
    idle_cycle();

    // out-of-range X destination
    send(16'h8005, 1, 4'd1, 5'b00001, st);
    @(negedge clk);
    check("oor_dest_err", 32'(dest_err), 32'd1);
    check("oor_port", 32'(port_num), 32'd1);
    check("oor_proto_err", 32'(proto_err), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("oor_dest_pulse", 32'(dest_err), 32'd0);
    @(posedge clk);
    #1;
    send(16'h4077, 1, 4'd1, 5'b00001, st);
    idle_cycle();

    // reset mid-packet with a held flit
    out_ready = 1'b0;
    send(16'h8011, 1, 4'd2, 5'b00010, st);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_port", 32'(port_num), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0099, 0, 4'd0, 5'b0, st);
    @(negedge clk);
    check("mrst_drop_proto", 32'(proto_err), 32'd1);
    check("mrst_drop_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    repeat (3) idle_cycle();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
